jtdd_rom_arb: RTL and testbench
===============================

Name: jtdd_rom_arb

Overview:
- Shares one SDRAM read port between three graphics ROM clients: char (highest priority), scroll and object.
- Per client: detects address changes, issues a fetch, holds the returned byte, and reports rom_ok only when the data matches the address currently presented.
- Sits between the video layer modules and the SDRAM controller. Replaces per-layer direct ROM wiring.

Parameters:
CHAR_AW, 15, char ROM address width
SCR_AW, 17, scroll ROM address width
OBJ_AW, 18, object ROM address width
SDW_AW, 22, SDRAM word address width
DW, 8, data width (all clients)
CHAR_OFFSET, 22'h00000, SDRAM base of char ROM
SCR_OFFSET, 22'h08000, SDRAM base of scroll ROM
OBJ_OFFSET, 22'h28000, SDRAM base of object ROM

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
char_cs  in  1  char client wants data
char_addr  in  CHAR_AW  char ROM address
char_data  out  DW  char ROM data
char_ok  out  1  char_data valid for char_addr
scr_cs / scr_addr / scr_data / scr_ok  same roles, SCR_AW address
obj_cs / obj_addr / obj_data / obj_ok  same roles, OBJ_AW address
sdram_req  out  1  read request, held until ack
sdram_addr  out  SDW_AW  read address
sdram_ack  in  1  request accepted (one-cycle pulse)
sdram_rdy  in  1  read data valid (one-cycle pulse)
sdram_dout  in  DW  read data

Behaviour:
- Reset state: all x_ok=0, x_data=0, sdram_req=0, sdram_addr=0, FSM=IDLE, valid_x=0, last_x=0.
- Per client registers: last_x (latched address), valid_x, data_x.
- change_x = cs_x & (~valid_x | addr_x != last_x). Combinational, from current inputs.
- x_ok is registered each cycle: ok_x <= cs_x & valid_x & (addr_x==last_x) & ~(busy & owner==x).
  - x_ok drops the cycle after an address change.
  - x_ok stays low while cs_x=0.
- FSM states:
  - IDLE: if any change_x, pick the highest-priority one (char > scr > obj). Set owner, last_owner <= addr, valid_owner <= 0, sdram_addr <= OFFSET_owner + zero-extended addr, sdram_req <= 1. Go to WAIT_ACK.
  - WAIT_ACK: hold req and addr. On sdram_ack: req <= 0, go to WAIT_DATA.
  - WAIT_DATA: on sdram_rdy: data_owner <= sdram_dout, valid_owner <= 1, go to IDLE.
- Ack and rdy in the same cycle while in WAIT_ACK: treat as both. Latch data, drop req, go to IDLE.
- Minimum latency: address change at cycle 0 → req high at cycle 1 → ok high the cycle after rdy is sampled.
- Back-to-back requests: IDLE can start a new request in the cycle after the return to IDLE, giving one dead cycle between requests.
- Address changes while the client's own fetch is in flight:
  - The fetch completes and the data is stored with the old last_x.
  - The ok compare fails, so ok stays 0.
  - The next IDLE refetches.
  - No request is aborted.
- Priority is fixed. Char can starve others; video timing guarantees char idles between tile fetches.
- Offset addition wraps modulo 2^SDW_AW. No overflow flag.
- sdram_rdy or sdram_ack in IDLE is ignored. This covers stray pulses after a mid-operation reset.
- Reset mid-operation: immediate return to reset state. Any in-flight SDRAM read is abandoned and its rdy pulse is ignored.
- x_data holds its value while ok is low. Only a completed fetch updates it.

Decomposition:
- Shared package jtdd_rom_pkg:
  - FSM state enum: IDLE, WAIT_ACK, WAIT_DATA.
  - Client index constants: CHAR=0, SCR=1, OBJ=2.
  - Default offset constants.
- One natural sub-module: jtdd_rom_slot, instantiated three times.
  - Holds last/valid/data.
  - Computes change and ok.
  - Parameterised by AW.
- The top module holds the priority encoder, FSM and SDRAM mux.

Test Plan:
- Single fetch: after reset, char_cs=1, char_addr=15'h0123. Required: sdram_req=1 next cycle with sdram_addr=22'h00123. Ack at +2, rdy at +5 with dout=8'hA5. Required: char_data=8'hA5 and char_ok=1 at +6.
- Priority: scr and obj change in the same cycle, scr_addr=17'h00010. Required: first sdram_addr=22'h08010, obj served next; obj_ok stays 0 until its rdy.
- Change during flight: char_addr changes 0x0001→0x0002 while waiting for the 0x0001 data. Required: char_ok stays 0 after rdy, a second request issues for 22'h00002, and ok=1 with the new data after the second rdy.
- cs low: obj_cs=0 with the address changing. Required: no sdram_req. Raising obj_cs then triggers a fetch at OBJ_OFFSET+addr.
- Reset mid-op: assert rst during WAIT_DATA, then pulse sdram_rdy after release. Required: all ok=0, data=0, req=0, and the stray rdy is ignored.
- Same-cycle ack+rdy: assert both in the first WAIT_ACK cycle. Required: data latched, FSM back in IDLE, ok the next cycle.

Source files
------------

// File: rtl/jtdd_rom_pkg.sv
// Shared definitions for the graphics ROM arbiter.
// Purpose : FSM state encoding, client index constants and the default
//           SDRAM base offsets of the three graphics ROMs.
// Ports   : none (package).
package jtdd_rom_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  localparam int CHAR = 0;
  localparam int SCR  = 1;
  localparam int OBJ  = 2;

  localparam logic [21:0] DEF_CHAR_OFFSET = 22'h00000;
  localparam logic [21:0] DEF_SCR_OFFSET  = 22'h08000;
  localparam logic [21:0] DEF_OBJ_OFFSET  = 22'h28000;

endpackage

// File: rtl/jtdd_rom_slot.sv
// One ROM client slot of the arbiter.
// Purpose : remembers the last fetched address, whether its data is valid and
//           the data itself; flags address changes and produces a registered ok.
// Ports   : clk, rst        clock and synchronous active-high reset
//           cs, addr        client request and address
//           start           arbiter begins a fetch for this slot (latch addr)
//           done            fetch for this slot completed (latch din)
//           own_busy        arbiter will be busy on this slot next cycle
//           din             SDRAM read data
//           change          client needs a fetch (combinational)
//           data, ok        held ROM byte and its validity for addr
module jtdd_rom_slot #(
  parameter int AW = 15,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          start,
  input  logic          done,
  input  logic          own_busy,
  input  logic [DW-1:0] din,
  output logic          change,
  output logic [DW-1:0] data,
  output logic          ok
);

  logic [AW-1:0] last, last_nx;
  logic          valid, valid_nx;

  // ok is computed from the values last/valid take at this edge, so a fetch
  // that completes now reports ok on the very next cycle.
  always_comb begin
    last_nx  = start ? addr : last;
    valid_nx = start ? 1'b0 : (done ? 1'b1 : valid);
    change   = cs & (~valid | (addr != last));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last  <= '0;
      valid <= 1'b0;
      data  <= '0;
      ok    <= 1'b0;
    end else begin
      last  <= last_nx;
      valid <= valid_nx;
      if (done) data <= din;
      ok    <= cs & valid_nx & (addr == last_nx) & ~own_busy;
    end
  end

endmodule

// File: rtl/jtdd_rom_arb.sv
// Graphics ROM arbiter: shares one SDRAM read port between char (highest
// priority), scroll and object clients.
// Ports   : clk, rst                      clock, synchronous active-high reset
//           {char,scr,obj}_cs/_addr        client requests
//           {char,scr,obj}_data/_ok        client data and validity
//           sdram_req/_addr                read request held until ack
//           sdram_ack/_rdy/_dout           request accepted / data returned
module jtdd_rom_arb
  import jtdd_rom_pkg::*;
#(
  parameter int               CHAR_AW     = 15,
  parameter int               SCR_AW      = 17,
  parameter int               OBJ_AW      = 18,
  parameter int               SDW_AW      = 22,
  parameter int               DW          = 8,
  parameter logic [SDW_AW-1:0] CHAR_OFFSET = SDW_AW'(DEF_CHAR_OFFSET),
  parameter logic [SDW_AW-1:0] SCR_OFFSET  = SDW_AW'(DEF_SCR_OFFSET),
  parameter logic [SDW_AW-1:0] OBJ_OFFSET  = SDW_AW'(DEF_OBJ_OFFSET)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              char_cs,
  input  logic [CHAR_AW-1:0] char_addr,
  output logic [DW-1:0]     char_data,
  output logic              char_ok,
  input  logic              scr_cs,
  input  logic [SCR_AW-1:0] scr_addr,
  output logic [DW-1:0]     scr_data,
  output logic              scr_ok,
  input  logic              obj_cs,
  input  logic [OBJ_AW-1:0] obj_addr,
  output logic [DW-1:0]     obj_data,
  output logic              obj_ok,
  output logic              sdram_req,
  output logic [SDW_AW-1:0] sdram_addr,
  input  logic              sdram_ack,
  input  logic              sdram_rdy,
  input  logic [DW-1:0]     sdram_dout
);

  state_t            state, state_nx;
  logic [1:0]        owner, owner_nx;
  logic              req_nx;
  logic [SDW_AW-1:0] addr_nx;
  logic [2:0]        change, start, done, own_busy;

  jtdd_rom_slot #(.AW(CHAR_AW), .DW(DW)) u_char (
    .clk(clk), .rst(rst), .cs(char_cs), .addr(char_addr),
    .start(start[CHAR]), .done(done[CHAR]), .own_busy(own_busy[CHAR]),
    .din(sdram_dout), .change(change[CHAR]), .data(char_data), .ok(char_ok)
  );

  jtdd_rom_slot #(.AW(SCR_AW), .DW(DW)) u_scr (
    .clk(clk), .rst(rst), .cs(scr_cs), .addr(scr_addr),
    .start(start[SCR]), .done(done[SCR]), .own_busy(own_busy[SCR]),
    .din(sdram_dout), .change(change[SCR]), .data(scr_data), .ok(scr_ok)
  );

  jtdd_rom_slot #(.AW(OBJ_AW), .DW(DW)) u_obj (
    .clk(clk), .rst(rst), .cs(obj_cs), .addr(obj_addr),
    .start(start[OBJ]), .done(done[OBJ]), .own_busy(own_busy[OBJ]),
    .din(sdram_dout), .change(change[OBJ]), .data(obj_data), .ok(obj_ok)
  );

  // Fixed-priority pick in IDLE; ack and rdy arriving together in WAIT_ACK
  // complete the fetch at once. Pulses seen in IDLE are ignored.
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    req_nx   = sdram_req;
    addr_nx  = sdram_addr;
    start    = 3'b000;
    done     = 3'b000;
    case (state)
      IDLE: begin
        if (change[CHAR]) begin
          owner_nx = 2'(CHAR);
          addr_nx  = CHAR_OFFSET + SDW_AW'(char_addr);
          start    = 3'b001;
        end else if (change[SCR]) begin
          owner_nx = 2'(SCR);
          addr_nx  = SCR_OFFSET + SDW_AW'(scr_addr);
          start    = 3'b010;
        end else if (change[OBJ]) begin
          owner_nx = 2'(OBJ);
          addr_nx  = OBJ_OFFSET + SDW_AW'(obj_addr);
          start    = 3'b100;
        end
        if (|change) begin
          req_nx   = 1'b1;
          state_nx = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sdram_ack) begin
          req_nx = 1'b0;
          if (sdram_rdy) begin
            done     = 3'b001 << owner;
            state_nx = IDLE;
          end else begin
            state_nx = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (sdram_rdy) begin
          done     = 3'b001 << owner;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    own_busy = (state_nx != IDLE) ? (3'b001 << owner_nx) : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 2'd0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      sdram_req  <= req_nx;
      sdram_addr <= addr_nx;
    end
  end

endmodule

// File: tb/tb_jtdd_rom_arb.sv
// Testbench for jtdd_rom_arb: directed scenarios plus a randomized run
// compared against a behavioural model of the arbiter.
module tb_jtdd_rom_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        char_cs, scr_cs, obj_cs;
  logic [14:0] char_addr;
  logic [16:0] scr_addr;
  logic [17:0] obj_addr;
  logic [7:0]  char_data, scr_data, obj_data;
  logic        char_ok, scr_ok, obj_ok;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack, sdram_rdy;
  logic [7:0]  sdram_dout;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int m_last[3], m_data[3];
  bit m_valid[3], m_ok[3];
  bit m_req;
  int m_addr;
  int m_phase;   // 0 free, 1 waiting for acceptance, 2 waiting for data
  int m_owner;
  int offs[3] = '{'h00000, 'h08000, 'h28000};

  jtdd_rom_arb dut (
    .clk(clk), .rst(rst),
    .char_cs(char_cs), .char_addr(char_addr), .char_data(char_data), .char_ok(char_ok),
    .scr_cs(scr_cs), .scr_addr(scr_addr), .scr_data(scr_data), .scr_ok(scr_ok),
    .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .sdram_rdy(sdram_rdy), .sdram_dout(sdram_dout)
  );

  always #5 clk = ~clk;

  // One clock of the model, from the rules: the highest-priority client whose
  // address is new or unfetched gets the port; its data is stored on return;
  // a client is ok when its held data belongs to the address it presents.
  task automatic model_step();
    bit cs[3];
    int a[3];
    int s;
    cs = '{char_cs, scr_cs, obj_cs};
    a  = '{int'(char_addr), int'(scr_addr), int'(obj_addr)};
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        m_last[c] = 0; m_data[c] = 0; m_valid[c] = 0; m_ok[c] = 0;
      end
      m_req = 0; m_addr = 0; m_phase = 0; m_owner = 0;
      return;
    end
    if (m_phase == 0) begin
      s = -1;
      for (int c = 0; c < 3; c++)
        if (s < 0 && cs[c] && (!m_valid[c] || a[c] != m_last[c])) s = c;
      if (s >= 0) begin
        m_owner = s; m_last[s] = a[s]; m_valid[s] = 0;
        m_addr = (offs[s] + a[s]) % (1 << 22);
        m_req = 1; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (sdram_ack) begin
        m_req = 0;
        if (sdram_rdy) begin
          m_data[m_owner] = int'(sdram_dout); m_valid[m_owner] = 1; m_phase = 0;
        end else m_phase = 2;
      end
    end else if (sdram_rdy) begin
      m_data[m_owner] = int'(sdram_dout); m_valid[m_owner] = 1; m_phase = 0;
    end
    for (int c = 0; c < 3; c++)
      m_ok[c] = cs[c] && m_valid[c] && a[c] == m_last[c] && !(m_phase != 0 && m_owner == c);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Acknowledge a pending request after ack_dly cycles, return dout rdy_dly
  // cycles after the ack (0 means in the same cycle as the ack).
  task automatic serve(input int ack_dly, input int rdy_dly, input logic [7:0] dout);
    repeat (ack_dly) tick();
    sdram_ack = 1'b1;
    if (rdy_dly == 0) begin sdram_rdy = 1'b1; sdram_dout = dout; end
    tick();
    sdram_ack = 1'b0; sdram_rdy = 1'b0;
    if (rdy_dly > 0) begin
      repeat (rdy_dly - 1) tick();
      sdram_rdy = 1'b1; sdram_dout = dout;
      tick();
      sdram_rdy = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    char_cs = 0; scr_cs = 0; obj_cs = 0;
    char_addr = '0; scr_addr = '0; obj_addr = '0;
    sdram_ack = 0; sdram_rdy = 0; sdram_dout = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({char_ok, scr_ok, obj_ok, sdram_req} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_flags: observed %b required 0000", {char_ok, scr_ok, obj_ok, sdram_req});
    end
    checks++;
    if ({char_data, scr_data, obj_data, sdram_addr} !== 46'd0) begin
      errors++; $display("[TB] FAIL reset_values: observed %h required 0", {char_data, scr_data, obj_data, sdram_addr});
    end
  endtask

  task automatic test_single_fetch();
    char_cs = 1; char_addr = 15'h0123;
    tick();
    checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== 22'h00123) begin
      errors++; $display("[TB] FAIL single_req: observed req=%b addr=%h required req=1 addr=000123", sdram_req, sdram_addr);
    end
    serve(1, 3, 8'hA5);
    checks++;
    if (char_data !== 8'hA5 || char_ok !== 1'b1) begin
      errors++; $display("[TB] FAIL single_data: observed data=%h ok=%b required data=a5 ok=1", char_data, char_ok);
    end
    char_cs = 0;
    tick();
  endtask

  task automatic test_priority();
    scr_cs = 1; scr_addr = 17'h00010; obj_cs = 1; obj_addr = 18'h00200;
    tick();
    checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== 22'h08010) begin
      errors++; $display("[TB] FAIL prio_first: observed req=%b addr=%h required req=1 addr=008010", sdram_req, sdram_addr);
    end
    serve(1, 2, 8'h3C);
    checks++;
    if (scr_ok !== 1'b1 || scr_data !== 8'h3C || obj_ok !== 1'b0 || sdram_req !== 1'b0) begin
      errors++; $display("[TB] FAIL prio_scr_done: observed scr_ok=%b scr_data=%h obj_ok=%b req=%b required 1 3c 0 0", scr_ok, scr_data, obj_ok, sdram_req);
    end
    tick();
    checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== 22'h28200 || obj_ok !== 1'b0) begin
      errors++; $display("[TB] FAIL prio_obj_req: observed req=%b addr=%h obj_ok=%b required 1 028200 0", sdram_req, sdram_addr, obj_ok);
    end
    serve(1, 1, 8'h5A);
    checks++;
    if (obj_ok !== 1'b1 || obj_data !== 8'h5A || scr_ok !== 1'b1) begin
      errors++; $display("[TB] FAIL prio_obj_done: observed obj_ok=%b obj_data=%h scr_ok=%b required 1 5a 1", obj_ok, obj_data, scr_ok);
    end
    scr_cs = 0; obj_cs = 0;
    tick();
  endtask

  task automatic test_change_in_flight();
    char_cs = 1; char_addr = 15'h0001;
    tick();
    sdram_ack = 1; tick(); sdram_ack = 0;
    char_addr = 15'h0002;
    tick();
    sdram_rdy = 1; sdram_dout = 8'h11; tick(); sdram_rdy = 0;
    checks++;
    if (char_ok !== 1'b0 || char_data !== 8'h11) begin
      errors++; $display("[TB] FAIL flight_stale: observed ok=%b data=%h required ok=0 data=11", char_ok, char_data);
    end
    tick();
    checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== 22'h00002 || char_ok !== 1'b0) begin
      errors++; $display("[TB] FAIL flight_refetch: observed req=%b addr=%h ok=%b required 1 000002 0", sdram_req, sdram_addr, char_ok);
    end
    serve(1, 1, 8'h22);
    checks++;
    if (char_ok !== 1'b1 || char_data !== 8'h22) begin
      errors++; $display("[TB] FAIL flight_new: observed ok=%b data=%h required ok=1 data=22", char_ok, char_data);
    end
    char_cs = 0;
    tick();
  endtask

  task automatic test_cs_low();
    obj_cs = 0;
    for (int i = 0; i < 4; i++) begin
      obj_addr = 18'($urandom);
      tick();
      checks++;
      if (sdram_req !== 1'b0 || obj_ok !== 1'b0) begin
        errors++; $display("[TB] FAIL cslow_idle: observed req=%b ok=%b required 0 0", sdram_req, obj_ok);
      end
    end
    obj_cs = 1; obj_addr = 18'h12345;
    tick();
    checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== 22'h03A345) begin
      errors++; $display("[TB] FAIL cslow_fetch: observed req=%b addr=%h required 1 03a345", sdram_req, sdram_addr);
    end
    serve(2, 2, 8'h99);
    checks++;
    if (obj_ok !== 1'b1 || obj_data !== 8'h99) begin
      errors++; $display("[TB] FAIL cslow_data: observed ok=%b data=%h required 1 99", obj_ok, obj_data);
    end
    obj_cs = 0;
    tick();
  endtask

  task automatic test_same_cycle();
    char_cs = 1; char_addr = 15'h0055;
    tick();
    serve(0, 0, 8'h77);
    checks++;
    if (char_ok !== 1'b1 || char_data !== 8'h77 || sdram_req !== 1'b0) begin
      errors++; $display("[TB] FAIL same_cycle: observed ok=%b data=%h req=%b required 1 77 0", char_ok, char_data, sdram_req);
    end
    tick();
    checks++;
    if (sdram_req !== 1'b0 || char_ok !== 1'b1) begin
      errors++; $display("[TB] FAIL same_cycle_idle: observed req=%b ok=%b required 0 1", sdram_req, char_ok);
    end
    char_cs = 0;
    tick();
  endtask

  task automatic test_reset_midop();
    char_cs = 1; char_addr = 15'h7FFF;
    tick();
    sdram_ack = 1; tick(); sdram_ack = 0;
    rst = 1; char_cs = 0; scr_cs = 0; obj_cs = 0;
    tick();
    rst = 0;
    checks++;
    if ({char_ok, scr_ok, obj_ok, sdram_req} !== 4'b0000 || {char_data, scr_data, obj_data} !== 24'd0) begin
      errors++; $display("[TB] FAIL midop_reset: observed flags=%b data=%h required 0", {char_ok, scr_ok, obj_ok, sdram_req}, {char_data, scr_data, obj_data});
    end
    sdram_rdy = 1; sdram_dout = 8'hFF; tick(); sdram_rdy = 0;
    tick();
    checks++;
    if ({char_ok, scr_ok, obj_ok, sdram_req} !== 4'b0000 || {char_data, scr_data, obj_data} !== 24'd0) begin
      errors++; $display("[TB] FAIL midop_stray: observed flags=%b data=%h required 0", {char_ok, scr_ok, obj_ok, sdram_req}, {char_data, scr_data, obj_data});
    end
  endtask

  task automatic test_random();
    bit acked = 0;
    rst = 1; tick(); rst = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(7) == 0) char_cs = 1'($urandom);
      if ($urandom_range(7) == 0) scr_cs  = 1'($urandom);
      if ($urandom_range(7) == 0) obj_cs  = 1'($urandom);
      if ($urandom_range(5) == 0) char_addr = 15'($urandom_range(3));
      if ($urandom_range(5) == 0) scr_addr  = 17'($urandom_range(3)) | 17'h1FFF0;
      if ($urandom_range(5) == 0) obj_addr  = 18'($urandom_range(3)) | 18'h3FFF0;
      sdram_ack = 0; sdram_rdy = 0; sdram_dout = 8'($urandom);
      if (sdram_req && !acked) begin
        if ($urandom_range(2) == 0) begin
          sdram_ack = 1; acked = 1;
          if ($urandom_range(3) == 0) begin sdram_rdy = 1; acked = 0; end
        end
      end else if (acked) begin
        if ($urandom_range(2) == 0) begin sdram_rdy = 1; acked = 0; end
      end else if ($urandom_range(19) == 0) begin
        sdram_rdy = 1'($urandom); sdram_ack = 1'($urandom);
      end
      rst = ($urandom_range(199) == 0);
      if (rst) acked = 0;
      tick();
      checks++;
      if ({char_ok, scr_ok, obj_ok} !== {m_ok[0], m_ok[1], m_ok[2]}) begin
        errors++; $display("[TB] FAIL rnd_ok cyc %0d: observed %b required %b", cyc, {char_ok, scr_ok, obj_ok}, {m_ok[0], m_ok[1], m_ok[2]});
      end
      checks++;
      if ({char_data, scr_data, obj_data} !== {8'(m_data[0]), 8'(m_data[1]), 8'(m_data[2])}) begin
        errors++; $display("[TB] FAIL rnd_data cyc %0d: observed %h required %h", cyc, {char_data, scr_data, obj_data}, {8'(m_data[0]), 8'(m_data[1]), 8'(m_data[2])});
      end
      checks++;
      if (sdram_req !== m_req || sdram_addr !== 22'(m_addr)) begin
        errors++; $display("[TB] FAIL rnd_sdram cyc %0d: observed req=%b addr=%h required req=%b addr=%h", cyc, sdram_req, sdram_addr, m_req, 22'(m_addr));
      end
    end
    rst = 0; sdram_ack = 0; sdram_rdy = 0;
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_single_fetch();
    test_priority();
    test_change_in_flight();
    test_cs_low();
    test_same_cycle();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
